snake_body: RTL and testbench

Multi-segment snake engine for the OLED snake game. It keeps up to `MAX_LEN` body segments on a coarse cell grid and advances them one cell per `tick` in the direction set by the buttons. It grows on `grow`, detects self-collision (and, optionally, wall collision), and answers the OLED pixel query with a registered body/head hit. It replaces the single-square, velocity-driven snake: it drives the OLED colour mux directly and feeds `head_x`/`head_y` to food logic.

---
 rtl/snake_body.sv | 253 +++++++++++++++++++++++++
 tb/tb_snake_body.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// Multi-segment snake engine: shift-register body on a cell grid, button steering,
// growth, collision detection and a registered pixel hit query. Define SNAKE_WRAP_EN for toroidal edges.
module snake_body #(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned INIT_LEN  = 3,
  parameter int unsigned GRID_W    = 24,
  parameter int unsigned GRID_H    = 16,
  parameter int unsigned CELL_LOG2 = 2,
  parameter int unsigned START_X   = 12,
  parameter int unsigned START_Y   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       restart,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       grow,
  input  logic [7:0] pixel_x,
  input  logic [7:0] pixel_y,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [5:0] length,
  output logic       running,
  output logic       dead,
  output logic       pixel_body,
  output logic       pixel_head
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t     r_state;
  state_t     w_state_nxt;
  dir_t       r_dir;
  dir_t       r_pend_dir;
  dir_t       w_req_dir;
  dir_t       w_cmp_dir;
  logic       w_req_vld;

  logic [4:0] r_seg_x [MAX_LEN];
  logic [4:0] r_seg_y [MAX_LEN];
  logic [5:0] r_length;
  logic       r_grow_pend;
  logic       r_pix_body;
  logic       r_pix_head;

  logic [4:0] w_nh_x;
  logic [4:0] w_nh_y;
  logic       w_wall;
  logic       w_self_hit;
  logic       w_grow_eff;
  logic       w_tick_run;
  logic       w_collide;
  logic       w_move;
  logic [7:0] w_cell_x;
  logic [7:0] w_cell_y;
  logic       w_pix_body;
  logic       w_pix_head;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

  // Button priority U > D > L > R
  always_comb begin
    w_req_vld = btnU | btnD | btnL | btnR;
    w_req_dir = DIR_RIGHT;
    if (btnU)      w_req_dir = DIR_UP;
    else if (btnD) w_req_dir = DIR_DOWN;
    else if (btnL) w_req_dir = DIR_LEFT;
    else if (btnR) w_req_dir = DIR_RIGHT;
  end

  // Candidate head: explicit edge compares, no arithmetic wrap-around
  always_comb begin
    w_nh_x = r_seg_x[0];
    w_nh_y = r_seg_y[0];
    w_wall = 1'b0;
    case (r_pend_dir)
      DIR_UP: begin
        if (r_seg_y[0] == 5'd0) begin
`ifdef SNAKE_WRAP_EN
          w_nh_y = 5'(GRID_H - 1);
`else
          w_wall = 1'b1;
`endif
        end else begin
          w_nh_y = r_seg_y[0] - 5'd1;
        end
      end
      DIR_DOWN: begin
        if (r_seg_y[0] == 5'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          w_nh_y = 5'd0;
`else
          w_wall = 1'b1;
`endif
        end else begin
          w_nh_y = r_seg_y[0] + 5'd1;
        end
      end
      DIR_LEFT: begin
        if (r_seg_x[0] == 5'd0) begin
`ifdef SNAKE_WRAP_EN
          w_nh_x = 5'(GRID_W - 1);
`else
          w_wall = 1'b1;
`endif
        end else begin
          w_nh_x = r_seg_x[0] - 5'd1;
        end
      end
      default: begin
        if (r_seg_x[0] == 5'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          w_nh_x = 5'd0;
`else
          w_wall = 1'b1;
`endif
        end else begin
          w_nh_x = r_seg_x[0] + 5'd1;
        end
      end
    endcase
  end

  assign w_grow_eff = r_grow_pend | grow;

  // The tail cell is vacated by the move unless the snake is growing
  always_comb begin
    w_self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (r_seg_x[i] == w_nh_x && r_seg_y[i] == w_nh_y) begin
        if ((6'(i) + 6'd1 < r_length) || (w_grow_eff && (6'(i) < r_length)))
          w_self_hit = 1'b1;
      end
    end
  end

  assign w_tick_run = (r_state == S_RUN) && tick && !restart;
  assign w_collide  = w_tick_run && (w_wall || w_self_hit);
  assign w_move     = w_tick_run && !w_collide;
  // Requests arriving on a move cycle are judged against the direction being committed
  assign w_cmp_dir  = w_move ? r_pend_dir : r_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    running     = (r_state == S_RUN);
    dead        = (r_state == S_DEAD);
    if (restart) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_req_vld) w_state_nxt = S_RUN;
        S_RUN:   if (w_collide) w_state_nxt = S_DEAD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir      <= DIR_RIGHT;
      r_pend_dir <= DIR_RIGHT;
    end else if (restart) begin
      r_dir      <= DIR_RIGHT;
      r_pend_dir <= DIR_RIGHT;
    end else if (r_state == S_IDLE) begin
      if (w_req_vld) begin
        r_dir      <= w_req_dir;
        r_pend_dir <= w_req_dir;
      end
    end else if (r_state == S_RUN) begin
      if (w_move) r_dir <= r_pend_dir;
      if (w_req_vld && (w_req_dir != opposite(w_cmp_dir))) r_pend_dir <= w_req_dir;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= (i < INIT_LEN) ? 5'(START_X - i) : '0;
        r_seg_y[i] <= (i < INIT_LEN) ? 5'(START_Y) : '0;
      end
      r_length    <= 6'(INIT_LEN);
      r_grow_pend <= 1'b0;
    end else if (restart) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= (i < INIT_LEN) ? 5'(START_X - i) : '0;
        r_seg_y[i] <= (i < INIT_LEN) ? 5'(START_Y) : '0;
      end
      r_length    <= 6'(INIT_LEN);
      r_grow_pend <= 1'b0;
    end else if (w_move) begin
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0]  <= w_nh_x;
      r_seg_y[0]  <= w_nh_y;
      if (w_grow_eff && (r_length < 6'(MAX_LEN))) r_length <= r_length + 6'd1;
      r_grow_pend <= 1'b0;
    end else if (grow && (r_state != S_DEAD)) begin
      r_grow_pend <= 1'b1;
    end
  end

  assign w_cell_x = pixel_x >> CELL_LOG2;
  assign w_cell_y = pixel_y >> CELL_LOG2;

  always_comb begin
    w_pix_body = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < r_length) && ({3'b000, r_seg_x[i]} == w_cell_x) &&
          ({3'b000, r_seg_y[i]} == w_cell_y))
        w_pix_body = 1'b1;
    end
    w_pix_head = ({3'b000, r_seg_x[0]} == w_cell_x) && ({3'b000, r_seg_y[0]} == w_cell_y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_body <= 1'b0;
      r_pix_head <= 1'b0;
    end else if (restart) begin
      r_pix_body <= 1'b0;
      r_pix_head <= 1'b0;
    end else begin
      r_pix_body <= w_pix_body;
      r_pix_head <= w_pix_head;
    end
  end

  assign head_x     = r_seg_x[0];
  assign head_y     = r_seg_y[0];
  assign length     = r_length;
  assign pixel_body = r_pix_body;
  assign pixel_head = r_pix_head;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: expectations queued at stimulus time, drained after each edge.
module tb_snake_body;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, restart = 1'b0, grow = 1'b0;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [7:0] pixel_x = 8'd0, pixel_y = 8'd0;
  logic [4:0] head_x, head_y;
  logic [5:0] length;
  logic       running, dead, pixel_body, pixel_head;

  localparam int unsigned K_HX = 0, K_HY = 1, K_LEN = 2, K_RUN = 3, K_DEAD = 4, K_PB = 5, K_PH = 6;

  typedef struct {
    string       tag;
    int unsigned kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  snake_body #(
    .MAX_LEN(16), .INIT_LEN(3), .GRID_W(24), .GRID_H(16),
    .CELL_LOG2(2), .START_X(12), .START_Y(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .restart(restart),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .grow(grow),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .head_x(head_x), .head_y(head_y), .length(length),
    .running(running), .dead(dead), .pixel_body(pixel_body), .pixel_head(pixel_head)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int unsigned kind);
    case (kind)
      K_HX:    return 32'(head_x);
      K_HY:    return 32'(head_y);
      K_LEN:   return 32'(length);
      K_RUN:   return 32'(running);
      K_DEAD:  return 32'(dead);
      K_PB:    return 32'(pixel_body);
      default: return 32'(pixel_head);
    endcase
  endfunction

  task automatic push(input string tag, input int unsigned kind, input int unsigned v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = 32'(v);
    sb.push_back(e);
  endtask

  task automatic exp_pos(input string tag, input int unsigned x, input int unsigned y);
    push({tag, ".hx"}, K_HX, x);
    push({tag, ".hy"}, K_HY, y);
  endtask

  task automatic exp_status(input string tag, input int unsigned len, input int unsigned run,
                            input int unsigned dd);
    push({tag, ".len"}, K_LEN, len);
    push({tag, ".run"}, K_RUN, run);
    push({tag, ".dead"}, K_DEAD, dd);
  endtask

  task automatic exp_pix(input string tag, input int unsigned b, input int unsigned h);
    push({tag, ".pbody"}, K_PB, b);
    push({tag, ".phead"}, K_PH, h);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btnU = u; btnD = d; btnL = l; btnR = r;
    cyc();
    btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
  endtask

  task automatic query(input int unsigned x, input int unsigned y);
    pixel_x = 8'(x);
    pixel_y = 8'(y);
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    exp_pos("rst", 12, 8); exp_status("rst", 3, 0, 0); exp_pix("rst", 0, 0);
    drain();
    reset_n = 1'b1;
    cyc();

    pulse_tick();
    exp_pos("idle_tick", 12, 8); exp_status("idle_tick", 3, 0, 0);
    drain();

    press(0, 0, 0, 1);
    exp_status("start", 3, 1, 0);
    drain();

    repeat (3) begin pulse_tick(); cyc(); end
    exp_pos("r3", 15, 8);
    drain();
    query(52, 32); exp_pix("tail", 1, 0); drain();
    query(60, 35); exp_pix("head", 1, 1); drain();
    query(48, 32); exp_pix("vacated", 0, 0); drain();

    press(0, 0, 1, 0);
    pulse_tick();
    exp_pos("rev_ignored", 16, 8);
    drain();

    press(1, 0, 1, 0);
    pulse_tick();
    exp_pos("u_over_l", 16, 7);
    drain();

    grow = 1'b1; pulse_tick(); grow = 1'b0;
    exp_pos("grow1", 16, 6); exp_status("grow1", 4, 1, 0);
    drain();

    grow = 1'b1; pulse_tick(); grow = 1'b0;
    press(0, 0, 1, 0); pulse_tick();
    press(0, 1, 0, 0); pulse_tick();
    exp_pos("turn_d", 15, 6); exp_status("turn_d", 5, 1, 0);
    drain();
    press(0, 0, 0, 1); pulse_tick();
    exp_pos("selfhit", 15, 6); exp_status("selfhit", 5, 0, 1);
    drain();

    query(60, 24); exp_pix("dead_head", 1, 1); drain();
    query(64, 24); exp_pix("dead_body", 1, 0); drain();

    pulse_tick();
    press(1, 0, 0, 0);
    exp_pos("dead_tick", 15, 6); exp_status("dead_tick", 5, 0, 1);
    drain();

    pixel_x = 8'd0; pixel_y = 8'd0;
    restart = 1'b1; cyc(); restart = 1'b0;
    exp_pos("restart", 12, 8); exp_status("restart", 3, 0, 0); exp_pix("restart", 0, 0);
    drain();

    query(48, 33); exp_pix("q48", 1, 1); drain();
    query(40, 33); exp_pix("q40", 1, 0); drain();
    query(60, 33); exp_pix("q60", 0, 0); drain();

    press(0, 0, 0, 1);
    repeat (11) pulse_tick();
    exp_pos("x23", 23, 8);
    drain();
    pulse_tick();
`ifdef SNAKE_WRAP_EN
    exp_pos("edge", 0, 8); exp_status("edge", 3, 1, 0);
`else
    exp_pos("edge", 23, 8); exp_status("edge", 3, 0, 1);
`endif
    drain();

    restart = 1'b1; cyc(); restart = 1'b0;
    press(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  press(0, 1, 0, 0);
      if (i == 10) press(0, 0, 1, 0);
      grow = 1'b1; pulse_tick(); grow = 1'b0;
      if (i == 11) begin
        exp_status("len15", 15, 1, 0);
        drain();
      end
    end
    exp_pos("sat", 7, 13); exp_status("sat", 16, 1, 0);
    drain();

    restart = 1'b1; tick = 1'b1; cyc(); restart = 1'b0; tick = 1'b0;
    exp_pos("restart_tick", 12, 8); exp_status("restart_tick", 3, 0, 0);
    drain();

    grow = 1'b1; cyc(); grow = 1'b0;
    press(0, 0, 0, 1);
    pulse_tick();
    exp_pos("idle_grow", 13, 8); exp_status("idle_grow", 4, 1, 0);
    drain();

    tick = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    exp_pos("async_rst", 12, 8); exp_status("async_rst", 3, 0, 0);
    drain();
    tick = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
